// File: rtl/frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_pkg
// Description : Shared types and constants for the serial frame transmitter.
//               Holds the FSM state enum, the preamble pattern and a helper
//               that sizes the shared bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] PREAMBLE = 4'b1011;
    localparam int         PRE_LEN  = 4;

    // The counter must hold the largest value it is ever loaded with:
    // PRE_LEN-1, DATA_W-1 or GAP-1.
    function automatic int cnt_width(input int data_w, input int gap);
        int max_val;
        max_val = PRE_LEN - 1;
        if (data_w - 1 > max_val) max_val = data_w - 1;
        if (gap - 1 > max_val)    max_val = gap - 1;
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_if
// Description : Word-in / bit-out bus of the frame transmitter.
//   data_in    : payload word offered by the source
//   data_valid : data_in is valid this cycle
//   data_ready : transmitter can accept a word this cycle
//   seq_out    : serial bit stream, one bit per clock
//   busy       : frame or inter-frame gap in progress
//   frame_done : pulse on the cycle carrying the payload LSB
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              seq_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, seq_out, busy, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, seq_out, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/tx_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : tx_bit_counter
// Description : Loadable down-counter with zero flag. Load has priority over
//               enable; the count saturates at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_value this edge
//   enable     : decrement this edge
//   load_value : value loaded on load
//   count      : current count
//   zero       : count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module tx_bit_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] load_value,
    output logic      [WIDTH-1:0] count,
    output logic                  zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx
// Description : Serial frame transmitter. Each accepted word is sent as a
//               4-bit preamble (1011) followed by DATA_W payload bits
//               MSB-first, then GAP idle zero bits.
//   clk   : clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset, aborts any frame in progress
//   bus   : frame_tx_if slave (data_in/data_valid/data_ready in,
//           seq_out/busy/frame_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input wire logic  clk,
    input wire logic  rst_n,
    frame_tx_if.slave bus
);

    localparam int CNT_W = cnt_width(DATA_W, GAP);

    localparam logic [CNT_W-1:0] c_pre_load  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] c_data_load = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_seq;
    logic              r_busy;
    logic              r_done;

    logic              w_cnt_load;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt_value;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_cnt_zero;
    logic              w_pre_bit;

    // In PRE the counter holds the index of the preamble bit now on seq_out,
    // so the next bit to send is one index lower.
    assign w_pre_bit = PREAMBLE[w_cnt[1:0] - 2'd1];

    // Counter control. In IDLE data_ready is 1, so data_valid alone marks a
    // handshake.
    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.data_valid) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = c_pre_load;
                end
            end
            ST_PRE: begin
                if (w_cnt_zero) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = c_data_load;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    if (GAP > 0) begin
                        w_cnt_load  = 1'b1;
                        w_cnt_value = c_gap_load;
                    end
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_GAP: begin
                w_cnt_en = 1'b1;
            end
            default: begin
                w_cnt_load  = 1'b1;
                w_cnt_value = '0;
            end
        endcase
    end

    tx_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_cnt_load),
        .enable     (w_cnt_en),
        .load_value (w_cnt_value),
        .count      (w_cnt),
        .zero       (w_cnt_zero)
    );

    // Outputs are registered one step ahead: each branch sets the value that
    // seq_out/busy/frame_done must show in the cycle after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_seq   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_seq  <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.data_valid) begin
                        r_shift <= bus.data_in;
                        r_state <= ST_PRE;
                        r_seq   <= PREAMBLE[PRE_LEN-1];
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (!w_cnt_zero) begin
                        r_seq <= w_pre_bit;
                    end else begin
                        r_state <= ST_DATA;
                        r_seq   <= r_shift[DATA_W-1];
                        r_shift <= r_shift << 1;
                        r_done  <= (DATA_W == 1);
                    end
                end
                ST_DATA: begin
                    if (!w_cnt_zero) begin
                        r_seq   <= r_shift[DATA_W-1];
                        r_shift <= r_shift << 1;
                        // Next bit shown is the LSB when one bit remains.
                        r_done  <= (w_cnt == CNT_W'(1));
                    end else if (GAP > 0) begin
                        r_state <= ST_GAP;
                        r_seq   <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_seq   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_seq <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_seq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_ready = (r_state == ST_IDLE);
    assign bus.seq_out    = r_seq;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_tx
// Description : Self-checking bench for frame_tx. Two instances run side by
//               side (DATA_W=8/GAP=1 and DATA_W=4/GAP=0) on shared stimulus.
//               Expected outputs come from a frame-position model; a
//               serial-to-parallel scoreboard recovers each payload word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_tx_if #(.DATA_W(8)) bus_a ();
    frame_tx_if #(.DATA_W(4)) bus_b ();

    frame_tx #(.DATA_W(8), .GAP(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    frame_tx #(.DATA_W(4), .GAP(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic seq_o [2];
    logic busy_o[2];
    logic done_o[2];
    logic rdy_o [2];
    assign seq_o[0]  = bus_a.seq_out;
    assign seq_o[1]  = bus_b.seq_out;
    assign busy_o[0] = bus_a.busy;
    assign busy_o[1] = bus_b.busy;
    assign done_o[0] = bus_a.frame_done;
    assign done_o[1] = bus_b.frame_done;
    assign rdy_o[0]  = bus_a.data_ready;
    assign rdy_o[1]  = bus_b.data_ready;

    // Model state: pos = index of the frame bit on seq_out (-1 = idle).
    int          w_len [2] = '{8, 4};
    int          g_len [2] = '{1, 0};
    int          pos   [2] = '{-1, -1};
    logic [15:0] word  [2];
    logic [15:0] sp    [2];
    logic [15:0] acc   [2][512];
    int          wr    [2] = '{0, 0};
    int          rd    [2] = '{0, 0};
    logic [3:0]  pre_bits = 4'b1011;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, req);
        end
    endtask

    function automatic logic [15:0] mask(input int i);
        return 16'((32'd1 << w_len[i]) - 1);
    endfunction

    function automatic logic exp_seq(input int i);
        if (pos[i] < 0) return 1'b0;
        if (pos[i] < 4) return pre_bits[3 - pos[i]];
        if (pos[i] < 4 + w_len[i]) return word[i][w_len[i] - 1 - (pos[i] - 4)];
        return 1'b0;
    endfunction

    task automatic check_now();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("seq%0d", i),   32'(seq_o[i]),  32'(exp_seq(i)));
            check($sformatf("busy%0d", i),  32'(busy_o[i]), 32'(pos[i] >= 0));
            check($sformatf("done%0d", i),  32'(done_o[i]), 32'(pos[i] == 3 + w_len[i]));
            check($sformatf("ready%0d", i), 32'(rdy_o[i]),  32'(pos[i] < 0));
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance model.
    task automatic cycle(input logic v, input logic [15:0] d);
        logic hs [2];
        bus_a.data_valid = v;
        bus_a.data_in    = d[7:0];
        bus_b.data_valid = v;
        bus_b.data_in    = d[3:0];
        #1;
        check_now();
        for (int i = 0; i < 2; i++) begin
            sp[i] = {sp[i][14:0], seq_o[i]};
            if (done_o[i]) begin
                if (rd[i] < wr[i]) begin
                    check($sformatf("sb_word%0d", i), 32'(sp[i] & mask(i)), 32'(acc[i][rd[i]]));
                    rd[i]++;
                end else begin
                    check($sformatf("sb_empty%0d", i), 32'(rd[i]), 32'(wr[i] + 1));
                end
            end
            hs[i] = (pos[i] < 0) && v;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                pos[i]         = 0;
                word[i]        = d & mask(i);
                acc[i][wr[i]]  = d & mask(i);
                wr[i]++;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] == 4 + w_len[i] + g_len[i]) pos[i] = -1;
            end
        end
        @(negedge clk);
    endtask

    // data_valid held high; the word changes after each accepted word on A.
    task automatic held(input logic [15:0] w0, input logic [15:0] w1);
        int k;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            logic idle_a;
            idle_a = (pos[0] < 0);
            cycle(k < 2, (k == 0) ? w0 : w1);
            if (idle_a && k < 2) k++;
        end
    endtask

    initial begin
        bus_a.data_valid = 1'b0;
        bus_a.data_in    = '0;
        bus_b.data_valid = 1'b0;
        bus_b.data_in    = '0;
        sp[0] = '0;
        sp[1] = '0;
        word[0] = '0;
        word[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_now();
        rst_n = 1'b1;

        // Single word, then drain
        cycle(1'b1, 16'h00A5);
        repeat (16) cycle(1'b0, 16'($urandom));

        // Back-to-back with data_valid held
        held(16'h00FF, 16'h0000);
        held(16'h000B, 16'h0001);

        // Word offered mid-frame must be ignored
        cycle(1'b1, 16'($urandom));
        repeat (6) cycle(1'b0, 16'($urandom));
        cycle(1'b1, 16'h003C);
        repeat (16) cycle(1'b0, 16'($urandom));

        // Random traffic
        for (int c = 0; c < 600; c++)
            cycle($urandom_range(0, 2) == 0, 16'($urandom));
        repeat (20) cycle(1'b0, 16'($urandom));

        // Reset while A shows its 6th frame bit
        cycle(1'b1, 16'($urandom));
        for (int k = 0; k < 20 && pos[0] != 5; k++) cycle(1'b0, 16'($urandom));
        check("pos_reach", 32'(pos[0]), 32'd5);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pos[i] >= 0 && pos[i] <= 3 + w_len[i]) wr[i]--;
            pos[i] = -1;
            sp[i]  = '0;
        end
        check_now();
        @(negedge clk);
        check_now();
        rst_n = 1'b1;

        // Clean frame right after reset release
        cycle(1'b1, 16'h005A);
        repeat (16) cycle(1'b0, 16'($urandom));

        for (int i = 0; i < 2; i++)
            check($sformatf("sb_drain%0d", i), 32'(rd[i]), 32'(wr[i]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 1..16.
REQ-002 Parameter GAP, default 1, number of idle zero bits after each frame; legal range 0..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  DATA_W  payload word to transmit.
REQ-006 data_valid  input  1  data_in is valid this cycle.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 seq_out  output  1  registered serial bit stream, one bit per clock.
REQ-009 busy  output  1  a frame or gap is in progress.
REQ-010 frame_done  output  1  one-cycle pulse marking the last payload bit.

Function
REQ-011 FSM states: IDLE, PRE, DATA, GAP.
REQ-012 A handshake occurs at a rising edge where data_valid=1 and data_ready=1.
REQ-013 data_ready shall be 1 only in IDLE; data_valid in any other state is ignored and the word is not captured.
REQ-014 On handshake: data_in is captured into the shift register, the FSM enters PRE, and the preamble bit counter loads 3.
REQ-015 Frame format on seq_out: preamble 1,0,1,1 (4 bits), then DATA_W payload bits MSB-first; frame length is 4+DATA_W cycles.
REQ-016 Latency: the first preamble bit shall appear on seq_out in the cycle immediately after the handshake edge.
REQ-017 PRE to DATA after the 4th preamble bit; the bit counter loads DATA_W-1.
REQ-018 DATA: the shift register shifts left one bit per cycle.
REQ-019 DATA to GAP after the last payload bit if GAP>0; otherwise DATA to IDLE.
REQ-020 GAP: seq_out=0 for exactly GAP cycles, then IDLE.
REQ-021 frame_done shall be 1 exactly in the cycle that seq_out carries payload bit 0 (the LSB), and 0 otherwise.
REQ-022 busy shall be 1 in PRE, DATA and GAP, and 0 in IDLE.
REQ-023 In IDLE, seq_out shall be 0.
REQ-024 With data_valid held at 1, frames shall be separated by exactly GAP zero cycles plus one IDLE cycle.
REQ-025 An undefined state encoding shall return to IDLE on the next edge with seq_out=0.
REQ-026 Counter widths shall be sized to hold max(3, DATA_W-1, GAP-1); no wrap-around inside a frame.

Reset
REQ-027 While reset=0, the block shall be in IDLE with seq_out=0, busy=0, frame_done=0, data_ready=1, shift register=0 and counter=0.
REQ-028 Reset asserted mid-frame shall abort the frame immediately (asynchronously); no partial bits follow deassertion.
REQ-029 The first handshake is possible at the first rising edge after reset deasserts.

Structure
REQ-030 Package frame_tx_pkg shall hold the state enum, PREAMBLE = 4'b1011 and PRE_LEN = 4.
REQ-031 One sub-module, tx_bit_counter: a loadable down-counter with load, enable and a zero flag, instantiated once and shared by PRE, DATA and GAP.
REQ-032 seq_out, frame_done and busy shall be driven directly from registers, with no combinational path from inputs.

Verification
REQ-033 DATA_W=8, GAP=1, single handshake with 8'hA5 -> seq_out = 1011 10100101 0, frame_done high on the 12th bit, then data_ready=1.
REQ-034 data_valid held at 1 with words 8'hFF then 8'h00 -> 1011 11111111 0 (idle) 1011 00000000 0, with the gap and idle cycles exactly as in REQ-024.
REQ-035 data_valid pulsed with 8'h3C during DATA of a prior frame -> word ignored; only the prior frame is transmitted.
REQ-036 reset driven low on the 6th bit of a frame -> seq_out=0, busy=0 and data_ready=1 immediately; the next handshake produces a clean full frame.
REQ-037 GAP=0, DATA_W=4, words 4'hB then 4'h1 -> 1011 1011 (idle) 1011 0001; busy drops for exactly one cycle between frames.
REQ-038 Scoreboard check on every run: a serial-to-parallel model recovers each payload word and matches every accepted data_in in order.
